spgemm_pp_gen: RTL and testbench
================================

Name: spgemm_pp_gen

Overview:
- Partial-product generator for row-wise (Gustavson) SpGEMM C = A x B. Sits directly upstream of the per-row merge/accumulate PE and drives its input stream (valid/ready, val, row, col).
- Holds B in CSR form in local arrays, loaded through a config write port.
- For each accepted nonzero A[i,k], walks row k of B and emits one product A[i,k]*B[k,j] per cycle, tagged (row=i, col=j).

Parameters:
- DATA_W, 32, width of A/B/product values.
- IDX_W, 16, width of row/column indices.
- B_ROWS, 2048, number of B rows; row_ptr array has B_ROWS+1 entries.
- B_NNZ, 4096, capacity of B col/val arrays; PTR_W = $clog2(B_NNZ+1) is derived.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_we  in  1  B config write strobe.
- cfg_sel  in  2  write target: 0=row_ptr, 1=b_col, 2=b_val, 3=reserved (write ignored).
- cfg_addr  in  IDX_W  array index.
- cfg_wdata  in  DATA_W  write data, truncated to the target width.
- a_valid  in  1  A nonzero valid.
- a_ready  out  1  A nonzero accepted when a_valid&&a_ready.
- a_row  in  IDX_W  A row i; stream is row-major.
- a_col  in  IDX_W  A column k, which selects the B row.
- a_val  in  DATA_W  A value.
- a_last  in  1  final A nonzero of the matrix.
- pp_valid  out  1  partial product valid.
- pp_ready  in  1  downstream ready.
- pp_val  out  DATA_W  product value.
- pp_row  out  IDX_W  = latched a_row.
- pp_col  out  IDX_W  = b_col[ptr].
- pp_last  out  1  final product of the matrix.
- done  out  1  one-cycle pulse when the whole A matrix has been processed.
- err  out  1  sticky error flag.

Behaviour:
- Reset (rst_n low, async): state=S_IDLE. a_ready, pp_valid, pp_last, done and err are all 0. pp_val/pp_row/pp_col are 0. The B arrays are not reset.
- B arrays are read combinationally (asynchronous read).

Config writes:
- A write takes effect at the clock edge only when state==S_IDLE. Otherwise it is dropped and err is set.
- a_ready=0 in any cycle with cfg_we=1.

FSM S_IDLE:
- a_ready = !cfg_we.
- On A handshake, latch row, val, last, start=row_ptr[a_col], end=row_ptr[a_col+1].
- If a_col >= B_ROWS: treat the B row as empty and set err.
- If start==end (empty row): stay in S_IDLE.
  - If a_last: pulse done on the next cycle; no pp_last is issued.
- Else go to S_EMIT with ptr=start.

FSM S_EMIT:
- a_ready=0, pp_valid=1.
- pp_col = b_col[ptr]; pp_val = low DATA_W bits of latched a_val * b_val[ptr] (unsigned, wrap).
- pp_last = latched last && (ptr==end-1).
- Outputs stay stable while pp_ready=0.
- On handshake: if ptr==end-1, go to S_IDLE; else ptr++.
- done pulses the cycle after the handshake that carried pp_last.

Timing and ordering:
- Latency: first pp_valid appears the cycle after the A handshake.
- Throughput: 1 product/cycle, plus one bubble cycle per A nonzero.
- Column order within one A nonzero follows B's stored order. Duplicates across k are expected; the downstream PE accumulates them.

Error conditions (err is sticky until reset):
- a_col >= B_ROWS.
- Dropped config write.
- row_ptr[a_col+1] < row_ptr[a_col] or end > B_NNZ; the A element is then treated as an empty row.

Other rules:
- Reset asserted mid-EMIT aborts immediately; any partially emitted row is lost.
- a_valid with a_ready=0: A inputs must be held stable by the source (standard valid/ready).

Test Plan:
- Load B row_ptr={0,2,2,3}, col={5,9,1}, val={3,4,7}. Send A(i=0,k=0,v=2,last=0) -> pp (0,5,6) then (0,9,8); a_ready returns high the cycle after the second handshake.
- Same B. Send A(i=1,k=1,v=5,last=1), an empty row -> no pp_valid; done pulses once, 1 cycle after acceptance; pp_last never asserted.
- Same B. Send A(1,0,1,0) then A(1,2,10,1) with pp_ready toggling 1,0,0,1 -> outputs held during stalls; sequence (1,5,3),(1,9,4),(1,1,70); pp_last only on the last; done the cycle after.
- Set a_val=32'h8000_0000, b_val=2 -> pp_val=0 (wrap).
- Send A with k=3000 -> consumed, no products, err=1 and stays 1. Separately, cfg_we during S_EMIT -> write dropped (read back unchanged), err=1.
- Assert rst_n low mid-EMIT -> pp_valid, pp_last, done and err go 0 asynchronously; after release, a_ready=1 and a fresh A element is processed correctly using the retained B.

Source files
------------

// File: rtl/spgemm_pp_gen.sv
// spgemm_pp_gen: Gustavson SpGEMM partial-product generator; walks B row k for each A[i,k] and emits A[i,k]*B[k,j] tagged (i,j).
// Ports:
//   clk, rst_n                             clock, async active-low reset
//   cfg_we/cfg_sel/cfg_addr/cfg_wdata      B CSR load port (0=row_ptr, 1=b_col, 2=b_val, 3=ignored)
//   a_valid/a_ready/a_row/a_col/a_val/a_last   A nonzero input stream
//   pp_valid/pp_ready/pp_val/pp_row/pp_col/pp_last  partial-product output stream
//   done                                   one-cycle pulse after the final A nonzero is processed
//   err                                    sticky error flag
module spgemm_pp_gen #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 16,
  parameter int B_ROWS = 2048,
  parameter int B_NNZ  = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_sel,
  input  logic [IDX_W-1:0]  cfg_addr,
  input  logic [DATA_W-1:0] cfg_wdata,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [IDX_W-1:0]  a_row,
  input  logic [IDX_W-1:0]  a_col,
  input  logic [DATA_W-1:0] a_val,
  input  logic              a_last,
  output logic              pp_valid,
  input  logic              pp_ready,
  output logic [DATA_W-1:0] pp_val,
  output logic [IDX_W-1:0]  pp_row,
  output logic [IDX_W-1:0]  pp_col,
  output logic              pp_last,
  output logic              done,
  output logic              err
);
  localparam int PTR_W = $clog2(B_NNZ + 1);
  localparam int RP_W  = $clog2(B_ROWS + 1);
  localparam int NA_W  = $clog2(B_NNZ);
  localparam logic [IDX_W-1:0] ROWS_I = IDX_W'(B_ROWS);
  localparam logic [IDX_W-1:0] NNZ_I  = IDX_W'(B_NNZ);
  localparam logic [PTR_W-1:0] NNZ_P  = PTR_W'(B_NNZ);
  typedef enum logic {S_IDLE, S_EMIT} state_t;
  state_t            r_state;
  logic [PTR_W-1:0]  r_row_ptr [B_ROWS+1];
  logic [IDX_W-1:0]  r_b_col [B_NNZ];
  logic [DATA_W-1:0] r_b_val [B_NNZ];
  logic [IDX_W-1:0]  r_row;
  logic [DATA_W-1:0] r_aval;
  logic              r_last;
  logic [PTR_W-1:0]  r_ptr;
  logic [PTR_W-1:0]  r_end;
  logic              r_done;
  logic              r_err;
  logic [RP_W-1:0]   w_k;
  logic [PTR_W-1:0]  w_start;
  logic [PTR_W-1:0]  w_end;
  logic              w_bad;
  logic              w_tail;
  logic              w_unused;
  assign w_k     = a_col[RP_W-1:0];
  assign w_start = r_row_ptr[w_k];
  assign w_end   = r_row_ptr[w_k + RP_W'(1)];
  // out-of-range k or an inconsistent row_ptr pair both degrade to an empty B row
  assign w_bad    = (a_col >= ROWS_I) || (w_end < w_start) || (w_end > NNZ_P);
  assign w_tail   = r_ptr == r_end - PTR_W'(1);
  assign w_unused = ^{cfg_wdata, cfg_addr, a_col};
  assign a_ready  = rst_n && (r_state == S_IDLE) && !cfg_we;
  assign pp_valid = r_state == S_EMIT;
  assign pp_row   = pp_valid ? r_row : '0;
  assign pp_col   = pp_valid ? r_b_col[r_ptr[NA_W-1:0]] : '0;
  assign pp_val   = pp_valid ? r_aval * r_b_val[r_ptr[NA_W-1:0]] : '0;
  assign pp_last  = pp_valid && r_last && w_tail;
  assign done     = r_done;
  assign err      = r_err;
  always_ff @(posedge clk) begin
    if (cfg_we && r_state == S_IDLE) begin
      if (cfg_sel == 2'd0 && cfg_addr <= ROWS_I) r_row_ptr[cfg_addr[RP_W-1:0]] <= cfg_wdata[PTR_W-1:0];
      if (cfg_sel == 2'd1 && cfg_addr < NNZ_I) r_b_col[cfg_addr[NA_W-1:0]] <= cfg_wdata[IDX_W-1:0];
      if (cfg_sel == 2'd2 && cfg_addr < NNZ_I) r_b_val[cfg_addr[NA_W-1:0]] <= cfg_wdata;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_row   <= '0;
      r_aval  <= '0;
      r_last  <= 1'b0;
      r_ptr   <= '0;
      r_end   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (cfg_we && r_state != S_IDLE) r_err <= 1'b1;
      if (r_state == S_IDLE) begin
        if (a_valid && a_ready) begin
          r_row  <= a_row;
          r_aval <= a_val;
          r_last <= a_last;
          r_ptr  <= w_start;
          r_end  <= w_end;
          if (w_bad) r_err <= 1'b1;
          if (w_bad || w_start == w_end) r_done <= a_last;
          else r_state <= S_EMIT;
        end
      end else if (pp_ready) begin
        if (w_tail) begin
          r_state <= S_IDLE;
          r_done  <= r_last;
        end else r_ptr <= r_ptr + PTR_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_spgemm_pp_gen.sv
// tb_spgemm_pp_gen: scoreboard bench for spgemm_pp_gen
module tb_spgemm_pp_gen;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        cfg_we = 0;
  logic [1:0]  cfg_sel = 0;
  logic [15:0] cfg_addr = 0;
  logic [31:0] cfg_wdata = 0;
  logic        a_valid = 0;
  logic        a_ready;
  logic [15:0] a_row = 0;
  logic [15:0] a_col = 0;
  logic [31:0] a_val = 0;
  logic        a_last = 0;
  logic        pp_valid;
  logic        pp_ready = 1;
  logic [31:0] pp_val;
  logic [15:0] pp_row;
  logic [15:0] pp_col;
  logic        pp_last;
  logic        done;
  logic        err;
  typedef struct packed {logic [31:0] v; logic [15:0] r; logic [15:0] c; logic l;} pp_t;
  pp_t         q[$];
  logic [31:0] m_rp [8] = '{default: 0};
  logic [31:0] m_col [8] = '{default: 0};
  logic [31:0] m_val [8] = '{default: 0};
  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  int          exp_done = 0;
  bit          stall = 0;
  bit          last_hs = 0;
  pp_t         held;
  spgemm_pp_gen dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .a_valid(a_valid), .a_ready(a_ready), .a_row(a_row),
    .a_col(a_col), .a_val(a_val), .a_last(a_last), .pp_valid(pp_valid),
    .pp_ready(pp_ready), .pp_val(pp_val), .pp_row(pp_row), .pp_col(pp_col),
    .pp_last(pp_last), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  always @(negedge clk) begin : mon
    pp_t got;
    pp_t exp;
    got = {pp_val, pp_row, pp_col, pp_last};
    if (!rst_n) begin
      stall = 0;
      last_hs = 0;
    end else begin
      if (stall && pp_valid) begin
        checks++;
        if (got !== held) begin errors++; $display("FAIL hold got %h exp %h", got, held); end
      end
      if (last_hs) begin
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL done_after_last got %b exp 1", done); end
      end
      if (done) done_cnt++;
      last_hs = 0;
      if (pp_valid && pp_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pp got %h exp none", got);
        end else begin
          exp = q.pop_front();
          if (got !== exp) begin errors++; $display("FAIL pp got %h exp %h", got, exp); end
        end
        last_hs = pp_last;
      end
      stall = pp_valid && !pp_ready;
      held = got;
    end
  end
  task automatic cfg_write(input logic [1:0] sel, input int addr, input logic [31:0] d, input bit apply);
    @(posedge clk); #1;
    cfg_we = 1; cfg_sel = sel; cfg_addr = 16'(addr); cfg_wdata = d;
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b0) begin errors++; $display("FAIL cfg_a_ready got %b exp 0", a_ready); end
    if (apply && sel == 2'd0) m_rp[addr] = d;
    if (apply && sel == 2'd1) m_col[addr] = d;
    if (apply && sel == 2'd2) m_val[addr] = d;
    @(posedge clk); #1;
    cfg_we = 0;
  endtask
  task automatic send_a(input int i, input int k, input logic [31:0] v, input bit last);
    int n = 0;
    @(posedge clk); #1;
    a_valid = 1; a_row = 16'(i); a_col = 16'(k); a_val = v; a_last = last;
    @(negedge clk);
    while (!a_ready && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (a_ready !== 1'b1) begin errors++; $display("FAIL a_accept got %b exp 1", a_ready); end
    if (k < 7 && m_rp[k+1] >= m_rp[k])
      for (int p = int'(m_rp[k]); p < int'(m_rp[k+1]); p++)
        q.push_back({32'(v * m_val[p]), 16'(i), 16'(m_col[p]), last && (p == int'(m_rp[k+1]) - 1)});
    if (last) exp_done++;
    @(posedge clk); #1;
    a_valid = 0;
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL drain got %0d left exp 0", q.size()); end
    checks++;
    if (done_cnt !== exp_done) begin errors++; $display("FAIL done_count got %0d exp %0d", done_cnt, exp_done); end
  endtask
  task automatic apply_reset();
    @(posedge clk); #2;
    rst_n = 0;
    q.delete();
    done_cnt = 0;
    exp_done = 0;
    @(posedge clk); #2;
    rst_n = 1;
  endtask
  task automatic test_reset();
    #12;
    checks++;
    if ({a_ready, pp_valid, pp_last, done, err} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got %b exp 00000", {a_ready, pp_valid, pp_last, done, err});
    end
    checks++;
    if ({pp_val, pp_row, pp_col} !== 64'b0) begin
      errors++; $display("FAIL reset_data got %h exp 0", {pp_val, pp_row, pp_col});
    end
    @(posedge clk); #2;
    rst_n = 1;
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", a_ready); end
  endtask
  task automatic test_basic();
    cfg_write(0, 0, 0, 1); cfg_write(0, 1, 2, 1); cfg_write(0, 2, 2, 1); cfg_write(0, 3, 3, 1);
    cfg_write(1, 0, 5, 1); cfg_write(1, 1, 9, 1); cfg_write(1, 2, 1, 1);
    cfg_write(2, 0, 3, 1); cfg_write(2, 1, 4, 1); cfg_write(2, 2, 7, 1);
    send_a(0, 0, 2, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({pp_valid, a_ready} !== ((c < 2) ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL basic_timing cyc %0d got %b exp %b", c, {pp_valid, a_ready}, (c < 2) ? 2'b10 : 2'b01);
      end
    end
    drain();
  endtask
  task automatic test_empty();
    send_a(1, 1, 5, 1);
    @(negedge clk);
    checks++;
    if ({done, pp_valid} !== 2'b10) begin errors++; $display("FAIL empty_done got %b exp 10", {done, pp_valid}); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL empty_pulse got %b exp 0", done); end
    drain();
  endtask
  task automatic test_stall();
    logic [7:0] pat;
    pat = 8'b1110_1001;
    fork
      begin send_a(1, 0, 1, 0); send_a(1, 2, 10, 1); end
      for (int c = 0; c < 8; c++) begin @(posedge clk); #1 pp_ready = pat[c]; end
    join
    pp_ready = 1;
    drain();
  endtask
  task automatic test_wrap();
    cfg_write(0, 4, 4, 1); cfg_write(1, 3, 7, 1); cfg_write(2, 3, 2, 1);
    send_a(2, 3, 32'h8000_0000, 0);
    drain();
  endtask
  task automatic test_err_cfg();
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL err_pre got %b exp 0", err); end
    pp_ready = 0;
    send_a(0, 0, 2, 0);
    cfg_write(2, 0, 99, 0);
    @(negedge clk);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL err_cfg got %b exp 1", err); end
    pp_ready = 1;
    drain();
    send_a(0, 0, 1, 0);
    drain();
  endtask
  task automatic test_reset_mid();
    pp_ready = 0;
    send_a(0, 2, 1, 1);
    @(negedge clk);
    checks++;
    if ({pp_valid, pp_last} !== 2'b11) begin errors++; $display("FAIL mid_pre got %b exp 11", {pp_valid, pp_last}); end
    #2 rst_n = 0;
    #1;
    checks++;
    if ({pp_valid, pp_last, done, err, a_ready} !== 5'b0) begin
      errors++; $display("FAIL mid_reset got %b exp 00000", {pp_valid, pp_last, done, err, a_ready});
    end
    q.delete();
    done_cnt = 0;
    exp_done = 0;
    @(posedge clk); #1;
    pp_ready = 1;
    rst_n = 1;
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got %b exp 1", a_ready); end
    send_a(3, 2, 4, 1);
    drain();
  endtask
  task automatic test_oor();
    send_a(0, 3000, 1, 0);
    @(negedge clk);
    checks++;
    if ({err, pp_valid} !== 2'b10) begin errors++; $display("FAIL oor got %b exp 10", {err, pp_valid}); end
    drain();
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL oor_sticky got %b exp 1", err); end
  endtask
  task automatic test_bad_ptr();
    apply_reset();
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL bad_pre got %b exp 0", err); end
    cfg_write(0, 5, 1, 1);
    send_a(5, 4, 1, 1);
    @(negedge clk);
    checks++;
    if ({done, err, pp_valid} !== 3'b110) begin errors++; $display("FAIL bad_ptr got %b exp 110", {done, err, pp_valid}); end
    drain();
  endtask
  initial begin
    test_reset();
    test_basic();
    test_empty();
    test_stall();
    test_wrap();
    test_err_cfg();
    test_reset_mid();
    test_oor();
    test_bad_ptr();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
